sample_scheduler: RTL

//  Periodic sampling controller for the converter's monitoring datapath. A programmable timer

---
 rtl/sample_scheduler.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/sample_scheduler.sv
// Periodic scan controller: a programmable timer launches bursts that request one sample
// per enabled channel (ascending order) and forward each capture over a valid/ready port.
module sample_scheduler #(
    parameter int NUM_CH   = 4,
    parameter int DATA_W   = 8,
    parameter int PERIOD_W = 16,
    parameter int ACK_TO   = 15
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic [PERIOD_W-1:0]       period,
    input  logic [NUM_CH-1:0]         ch_mask,
    input  logic                      clr_flags,
    output logic [$clog2(NUM_CH)-1:0] ch_sel,
    output logic                      sample_req,
    input  logic                      sample_ack,
    input  logic [DATA_W-1:0]         sample_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic [$clog2(NUM_CH)-1:0] out_ch,
    output logic                      busy,
    output logic                      overrun,
    output logic                      timeout
);
    localparam int CH_W  = $clog2(NUM_CH);
    localparam int CNT_W = $clog2(ACK_TO + 1);

    typedef enum logic [1:0] {IDLE, WAIT, REQ, OUT} state_t;

    state_t              state, state_next, adv_state;
    logic [PERIOD_W-1:0] timer, period_q, limit;
    logic                tick;
    logic [NUM_CH-1:0]   mask_q;
    logic [CNT_W-1:0]    ack_cnt;
    logic                stop_q, stop;
    logic                first_found, next_found;
    logic [CH_W-1:0]     first_ch, next_ch, ch_next;
    logic                load_ch, timeout_set, advance;

    // A new period is only picked up while the timer sits at zero, i.e. at a wrap.
    always_comb begin
        limit = (timer == '0) ? period : period_q;
        if (limit == '0) limit = PERIOD_W'(1);
    end

    assign tick = enable && (timer == limit - PERIOD_W'(1));
    assign stop = stop_q || !enable;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer    <= '0;
            period_q <= '0;
        end else begin
            if (timer == '0) period_q <= period;
            if (!enable || tick) timer <= '0;
            else                 timer <= timer + PERIOD_W'(1);
        end
    end

    // Lowest set bit of the live mask (burst start) and next set bit above ch_sel in the latched mask.
    always_comb begin
        first_found = 1'b0;
        first_ch    = '0;
        next_found  = 1'b0;
        next_ch     = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_mask[i]) begin
                first_found = 1'b1;
                first_ch    = CH_W'(i);
            end
            if (mask_q[i] && (CH_W'(i) > ch_sel)) begin
                next_found = 1'b1;
                next_ch    = CH_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next  = state;
        advance     = 1'b0;
        load_ch     = 1'b0;
        ch_next     = ch_sel;
        timeout_set = 1'b0;
        if (stop)            adv_state = IDLE;
        else if (next_found) adv_state = REQ;
        else                 adv_state = WAIT;
        unique case (state)
            IDLE: if (enable) state_next = WAIT;
            WAIT: begin
                if (!enable) begin
                    state_next = IDLE;
                end else if (tick && first_found) begin
                    state_next = REQ;
                    load_ch    = 1'b1;
                    ch_next    = first_ch;
                end
            end
            REQ: begin
                if (sample_ack) begin
                    state_next = OUT;
                end else if (ack_cnt == CNT_W'(ACK_TO - 1)) begin
                    timeout_set = 1'b1;
                    advance     = 1'b1;
                end
            end
            OUT: if (out_ready) advance = 1'b1;
            default: state_next = IDLE;
        endcase
        if (advance) begin
            state_next = adv_state;
            if (adv_state == REQ) begin
                load_ch = 1'b1;
                ch_next = next_ch;
            end
        end
    end

    // Handshake outputs decode straight from state so reset removes them without waiting for a clock.
    always_comb begin
        sample_req = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        unique case (state)
            REQ: begin
                sample_req = 1'b1;
                busy       = 1'b1;
            end
            OUT: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_sel   <= '0;
            out_data <= '0;
            out_ch   <= '0;
            ack_cnt  <= '0;
            mask_q   <= '0;
            stop_q   <= 1'b0;
            overrun  <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            if (load_ch) ch_sel <= ch_next;
            if (state == REQ && sample_ack) begin
                out_data <= sample_data;
                out_ch   <= ch_sel;
            end
            if (state == REQ && !load_ch) ack_cnt <= ack_cnt + CNT_W'(1);
            else                          ack_cnt <= '0;
            if (state == WAIT && tick) mask_q <= ch_mask;
            if (state_next == IDLE || state_next == WAIT) stop_q <= 1'b0;
            else if (busy && !enable)                     stop_q <= 1'b1;
            // A clear in the same cycle as a new event wins.
            if (clr_flags) begin
                overrun <= 1'b0;
                timeout <= 1'b0;
            end else begin
                if (tick && busy) overrun <= 1'b1;
                if (timeout_set)  timeout <= 1'b1;
            end
        end
    end
endmodule
